// File: rtl/dmx_frame_loader.sv
// Packs host channel bytes into 16-bit words for the DMX transmitter RAM and
// requests transmission on frame end. Optional build macro: DMX_AUTO_REFRESH_EN.
module dmx_frame_loader #(
  parameter int MAX_CHANNELS   = 512,
  parameter int BUSY_TIMEOUT   = 16,
  parameter int REFRESH_CYCLES = 24000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  input  logic        i_frame_end,
  input  logic        i_dmx_busy,
  output logic [7:0]  o_write_addr,
  output logic [15:0] o_write_data,
  output logic        o_write_strobe,
  output logic [9:0]  o_channel_count,
  output logic        o_start_strobe,
  output logic        o_overflow
);

  localparam int               TMR_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [9:0]       MAX_IDX  = 10'(MAX_CHANNELS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    FILL,
    FLUSH,
    ARM,
    SENT
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       idx_q, idx_d;
  logic [7:0]       hi_q, hi_d;
  logic             ready_q, ready_d;
  logic             wr_stb_q, wr_stb_d;
  logic [7:0]       addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic [9:0]       cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             ovf_q, ovf_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             accept;

`ifdef DMX_AUTO_REFRESH_EN
  localparam logic [24:0] REF_LAST = 25'(REFRESH_CYCLES - 1);
  logic [24:0] ref_q, ref_d;
  logic        sent_q, sent_d;
  logic        rfr_q, rfr_d;
`else
  // Refresh period only matters when automatic retransmission is built in.
  logic unused_refresh;
  assign unused_refresh = |25'(REFRESH_CYCLES);
`endif

  assign accept = i_byte_valid & ready_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= WAIT_IDLE;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      wr_stb_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      start_q  <= 1'b0;
      ovf_q    <= 1'b0;
      tmr_q    <= '0;
`ifdef DMX_AUTO_REFRESH_EN
      ref_q    <= '0;
      sent_q   <= 1'b0;
      rfr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      wr_stb_q <= wr_stb_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      ovf_q    <= ovf_d;
      tmr_q    <= tmr_d;
`ifdef DMX_AUTO_REFRESH_EN
      ref_q    <= ref_d;
      sent_q   <= sent_d;
      rfr_q    <= rfr_d;
`endif
    end
    hi_q <= hi_d;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hi_d     = hi_q;
    wr_stb_d = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    ovf_d    = ovf_q;
    tmr_d    = tmr_q;
`ifdef DMX_AUTO_REFRESH_EN
    ref_d    = ref_q;
    sent_d   = sent_q;
    rfr_d    = rfr_q;
`endif
    case (state_q)
      WAIT_IDLE: begin
        if (!i_dmx_busy) begin
          state_d = FILL;
          idx_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      FILL: begin
        if (accept) begin
          if (idx_q == MAX_IDX) begin
            ovf_d = 1'b1;
          end else begin
            idx_d = idx_q + 10'd1;
            if (!idx_q[0]) begin
              hi_d = i_byte;
            end else begin
              wr_stb_d = 1'b1;
              addr_d   = idx_q[8:1];
              data_d   = {hi_q, i_byte};
            end
          end
        end
        if (i_frame_end) begin
          state_d = FLUSH;
        end
`ifdef DMX_AUTO_REFRESH_EN
        // Idle between frames: resend the last frame once the period elapses.
        if (accept) begin
          ref_d = '0;
        end else if (!i_frame_end && sent_q && idx_q == '0) begin
          if (ref_q == REF_LAST) begin
            ref_d   = '0;
            rfr_d   = 1'b1;
            state_d = ARM;
          end else begin
            ref_d = ref_q + 25'd1;
          end
        end
`endif
      end
      FLUSH: begin
        if (idx_q[0]) begin
          wr_stb_d = 1'b1;
          addr_d   = idx_q[8:1];
          data_d   = {hi_q, 8'h00};
        end
        state_d = (idx_q == '0) ? WAIT_IDLE : ARM;
      end
      ARM: begin
        if (!i_dmx_busy) begin
          start_d = 1'b1;
          tmr_d   = '0;
          state_d = SENT;
`ifdef DMX_AUTO_REFRESH_EN
          cnt_d   = rfr_q ? cnt_q : idx_q;
          sent_d  = 1'b1;
          rfr_d   = 1'b0;
          ref_d   = '0;
`else
          cnt_d   = idx_q;
`endif
        end
      end
      SENT: begin
        // Busy may lag the strobe (divided transmitter clock); give up after the timeout.
        if (i_dmx_busy || tmr_q == TMR_LAST) begin
          state_d = WAIT_IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
    ready_d = (state_d == FILL);
  end

  assign o_byte_ready    = ready_q;
  assign o_write_strobe  = wr_stb_q;
  assign o_write_addr    = addr_q;
  assign o_write_data    = data_q;
  assign o_channel_count = cnt_q;
  assign o_start_strobe  = start_q;
  assign o_overflow      = ovf_q;

endmodule

// File: doc/dmx_frame_loader.md
Name: dmx_frame_loader

Overview:
- Upstream feeder for the DMX transmitter. Accepts a byte stream of channel values from the host interface (SPI/ESP32 bridge) with valid/ready handshake.
- Packs byte pairs into 16-bit words and writes them into the transmitter's 256x16 channel RAM.
- On frame end, publishes the channel count and issues the start strobe. Interlocks with the transmitter's busy flag so the RAM is never rewritten mid-transmission.

Parameters:
- MAX_CHANNELS, 512, maximum channel bytes stored per frame; extra bytes are dropped.
- BUSY_TIMEOUT, 16, i_clk cycles to wait for i_dmx_busy to rise after o_start_strobe before giving up.
- REFRESH_CYCLES, 24000000, i_clk cycles between automatic retransmissions. Used only with DMX_AUTO_REFRESH_EN.

Ports:
- i_clk  in  1  system clock (24 MHz)
- i_rst  in  1  synchronous, active-high reset
- i_byte  in  8  channel value, in channel order starting at channel 0
- i_byte_valid  in  1  i_byte is valid this cycle
- o_byte_ready  out  1  loader accepts i_byte this cycle
- i_frame_end  in  1  one-cycle pulse; the frame is complete
- i_dmx_busy  in  1  transmitter busy flag
- o_write_addr  out  8  RAM word address
- o_write_data  out  16  RAM word; [15:8] = even channel, [7:0] = odd channel
- o_write_strobe  out  1  one-cycle RAM write enable
- o_channel_count  out  10  channel count of the frame being sent
- o_start_strobe  out  1  one-cycle transmit request
- o_overflow  out  1  sticky: the current frame exceeded MAX_CHANNELS

Behaviour:
- Reset values, all registered:
  - o_byte_ready=0, o_write_strobe=0, o_start_strobe=0.
  - o_write_addr=0, o_write_data=0, o_channel_count=0, o_overflow=0.
  - byte index=0, state=WAIT_IDLE.
- Byte index is 10 bits and saturates at MAX_CHANNELS.
- A byte is accepted when i_byte_valid && o_byte_ready.
- States:
  - WAIT_IDLE: o_byte_ready=0. When i_dmx_busy==0 → FILL, with byte index=0 and o_overflow=0.
  - FILL: o_byte_ready=1.
    - Even-index byte: latched into the high-byte register.
    - Odd-index byte: next cycle o_write_strobe=1, o_write_addr=index[8:1], o_write_data={hi,byte}.
    - Bytes arriving at index==MAX_CHANNELS are accepted and discarded; o_overflow is set.
    - On i_frame_end → FLUSH. If a byte is accepted in the same cycle, it belongs to this frame.
  - FLUSH: o_byte_ready=0.
    - If the count is odd, write {hi,8'h00} at address count[8:1] (one strobe).
    - If count==0 → WAIT_IDLE; no transmission occurs.
    - Otherwise → ARM.
  - ARM: when i_dmx_busy==0, pulse o_start_strobe for one cycle, load o_channel_count=count, → SENT.
  - SENT: o_byte_ready=0.
    - Wait for i_dmx_busy==1, then → WAIT_IDLE.
    - If BUSY_TIMEOUT cycles pass without busy rising → WAIT_IDLE anyway.
    - The transmitter runs on a divided clock, so busy may lag the strobe by up to 8 cycles.
- Latencies:
  - Write strobe occurs 1 cycle after the odd byte is accepted.
  - o_start_strobe occurs at least 2 cycles after i_frame_end (flush cycle, then arm), when busy is already low.
- i_frame_end outside FILL is ignored.
- At most one write strobe per cycle; the flush write never coincides with a stream write.
- o_channel_count is stable from the start strobe until the next start strobe.
- Reset mid-frame: RAM contents are kept, no strobe is issued, state returns to WAIT_IDLE.

Optional Feature:
- Macro: DMX_AUTO_REFRESH_EN.
- Defined:
  - A 25-bit refresh counter counts i_clk cycles in FILL while byte index==0 and at least one frame has been sent since reset.
  - When the counter reaches REFRESH_CYCLES-1, go to ARM and resend the previous frame with the previous o_channel_count.
  - Any accepted byte or any start strobe clears the counter.
- Undefined:
  - No counter is built; transmission occurs only after i_frame_end.

Test Plan:
- Reset, i_dmx_busy=0, stream bytes 0xE0,0x0F,0x4B,0xFF then i_frame_end.
  → Writes (addr0,0xE00F) and (addr1,0x4BFF); o_start_strobe once; o_channel_count=4.
- Three bytes 0x11,0x22,0x33 then i_frame_end.
  → Writes (0,0x1122) and flush (1,0x3300); o_channel_count=3.
- Hold i_dmx_busy=1 during frame_end.
  → No strobe until busy falls; strobe within 1 cycle of the fall; o_byte_ready=0 throughout.
- 515 bytes then i_frame_end.
  → 256 writes, addresses 0..255; o_overflow=1; o_channel_count=512.
- i_frame_end with zero bytes.
  → No write and no o_start_strobe.
- With DMX_AUTO_REFRESH_EN and REFRESH_CYCLES=100: send a 2-byte frame, stay idle.
  → o_start_strobe repeats every ~100 cycles with o_channel_count=2 and no new RAM writes.
